// File: rtl/fetch_queue.sv
// fetch_queue: PC generator plus DEPTH-entry instruction queue feeding decode.
// Optional same-cycle bypass of an empty queue: define FETCH_BYPASS_EN.
module fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [ADDR_WIDTH-1:0]     inst_addr_o,
    output logic                      inst_ce_o,
    input  logic [INST_WIDTH-1:0]     inst_i,
    input  logic                      redirect_i,
    input  logic [ADDR_WIDTH-1:0]     redirect_addr_i,
    input  logic                      deq_i,
    output logic                      valid_o,
    output logic [INST_WIDTH-1:0]     inst_o,
    output logic [ADDR_WIDTH-1:0]     inst_addr_out_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [INST_WIDTH-1:0] inst_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    logic [CW:0] occ;
    logic        issue;
    logic        push;
    logic        byp;
    logic        pop;
    logic        wr_en;

    // Issue/push/pop decisions and next-state for all control registers
    always_comb begin
        occ         = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
        issue       = ~rst & ~redirect_i & (occ < DEPTH_W);
        push        = pending_q & ~redirect_i;
`ifdef FETCH_BYPASS_EN
        byp         = push & (count_q == '0);
`else
        byp         = 1'b0;
`endif
        pop         = deq_i & (count_q != '0);
        wr_en       = push & ~(byp & deq_i);

        pc_d        = pc_q;
        pending_d   = issue;
        pend_addr_d = pend_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (issue) begin
            pc_d        = pc_q + ADDR_WIDTH'(4);
            pend_addr_d = pc_q;
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (redirect_i) begin
            pc_d      = {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};
            pending_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end
    end

    // Control register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Queue storage; cleared on reset so the head reads zero while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (wr_en) begin
            inst_q[wr_ptr_q] <= inst_i;
            addr_q[wr_ptr_q] <= pend_addr_q;
        end
    end

    assign inst_ce_o   = issue;
    assign inst_addr_o = pc_q;
    assign count_o     = count_q;

`ifdef FETCH_BYPASS_EN
    assign valid_o         = (count_q != '0) | byp;
    assign inst_o          = byp ? inst_i : inst_q[rd_ptr_q];
    assign inst_addr_out_o = byp ? pend_addr_q : addr_q[rd_ptr_q];
`else
    assign valid_o         = (count_q != '0);
    assign inst_o          = inst_q[rd_ptr_q];
    assign inst_addr_out_o = addr_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (DEPTH=4, RESET_PC=0).
// Instruction memory model returns addr | 0xA000 one cycle after a request.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] inst_addr;
    logic        inst_ce;
    logic [31:0] inst_i;
    logic        redirect;
    logic [31:0] raddr;
    logic        deq;
    logic        valid;
    logic [31:0] inst_o;
    logic [31:0] addr_out;
    logic [2:0]  count;

    int nv   = 0;
    int nerr = 0;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    fetch_queue #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .DEPTH(4),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inst_addr_o(inst_addr),
        .inst_ce_o(inst_ce),
        .inst_i(inst_i),
        .redirect_i(redirect),
        .redirect_addr_i(raddr),
        .deq_i(deq),
        .valid_o(valid),
        .inst_o(inst_o),
        .inst_addr_out_o(addr_out),
        .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered instruction memory with 1-cycle latency
    always @(posedge clk) begin
        if (inst_ce) inst_i <= inst_addr | 32'hA000;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nv++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        deq = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        deq = 1'b0;
        redirect = 1'b0;
        raddr = '0;
        inst_i = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_ce", 32'(inst_ce), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_addrout", addr_out, 0);
        chk("rst_pc", inst_addr, 0);

        // Streaming with deq held high
        @(negedge clk);
        rst = 1'b0;
        deq = 1'b1;
        #1;
        chk("s_ce0", 32'(inst_ce), 1);
        chk("s_addr0", inst_addr, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("s_ce", 32'(inst_ce), 1);
            chk("s_addr", inst_addr, 32'(4 * k));
            if (k >= LAT) begin
                chk("s_valid", 32'(valid), 1);
                chk("s_inst", inst_o, 32'hA000 + 32'(4 * (k - LAT)));
                chk("s_count", 32'(count), 32'(LAT - 1));
            end else begin
                chk("s_valid0", 32'(valid), 0);
            end
        end

        // Fill with deq low, then single pop
        rst_pulse();
        chk("f_ce0", 32'(inst_ce), 1);
        chk("f_addr0", inst_addr, 0);
        repeat (5) @(negedge clk);
        chk("f_count", 32'(count), 4);
        chk("f_ce", 32'(inst_ce), 0);
        chk("f_valid", 32'(valid), 1);
        chk("f_inst", inst_o, 32'hA000);
        deq = 1'b1;
        #1;
        chk("f_ce_pop", 32'(inst_ce), 0);
        @(negedge clk);
        deq = 1'b0;
        #1;
        chk("f_count3", 32'(count), 3);
        chk("f_ce1", 32'(inst_ce), 1);
        chk("f_addr10", inst_addr, 32'h10);
        chk("f_inst1", inst_o, 32'hA004);
        repeat (2) @(negedge clk);
        chk("f_count4", 32'(count), 4);
        chk("f_ce_full", 32'(inst_ce), 0);

        // Redirect with count=2 and a request in flight
        rst_pulse();
        repeat (3) @(negedge clk);
        chk("r_count2", 32'(count), 2);
        redirect = 1'b1;
        raddr = 32'h103;
        #1;
        chk("r_ce_redir", 32'(inst_ce), 0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("r_count0", 32'(count), 0);
        chk("r_valid0", 32'(valid), 0);
        chk("r_ce", 32'(inst_ce), 1);
        chk("r_addr", inst_addr, 32'h100);
        repeat (2) @(negedge clk);
        chk("r_valid", 32'(valid), 1);
        chk("r_addrout", addr_out, 32'h100);
        chk("r_inst", inst_o, 32'hA100);

        // Redirect and deq together with count=3
        rst_pulse();
        repeat (4) @(negedge clk);
        chk("rd_count3", 32'(count), 3);
        redirect = 1'b1;
        deq = 1'b1;
        raddr = 32'h200;
        #1;
        chk("rd_ce", 32'(inst_ce), 0);
        @(negedge clk);
        redirect = 1'b0;
        deq = 1'b0;
        #1;
        chk("rd_count0", 32'(count), 0);
        chk("rd_ce1", 32'(inst_ce), 1);
        chk("rd_addr", inst_addr, 32'h200);
        repeat (2) @(negedge clk);
        chk("rd_valid", 32'(valid), 1);
        chk("rd_inst", inst_o, 32'hA200);

        // Asynchronous reset mid-stream
        rst_pulse();
        repeat (4) @(negedge clk);
        chk("a_count3", 32'(count), 3);
        #2 rst = 1'b1;
        #1;
        chk("a_valid", 32'(valid), 0);
        chk("a_count", 32'(count), 0);
        chk("a_ce", 32'(inst_ce), 0);
        chk("a_inst", inst_o, 0);
        chk("a_addrout", addr_out, 0);
        chk("a_pc", inst_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("a_ce1", 32'(inst_ce), 1);
        chk("a_addr0", inst_addr, 0);
        repeat (2) @(negedge clk);
        chk("a_valid1", 32'(valid), 1);
        chk("a_inst1", inst_o, 32'hA000);
        chk("a_addrout1", addr_out, 0);

`ifdef FETCH_BYPASS_EN
        // Bypass of an empty queue
        rst_pulse();
        deq = 1'b1;
        @(negedge clk);
        chk("b_valid", 32'(valid), 1);
        chk("b_inst", inst_o, 32'hA000);
        chk("b_count", 32'(count), 0);
        @(negedge clk);
        chk("b_inst1", inst_o, 32'hA004);
        chk("b_count1", 32'(count), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-register PC/fetch stage of the 5-stage RISC-V core. It generates the PC and issues requests to a registered instruction memory with 1-cycle latency. Returned instructions are buffered, paired with their addresses, in a DEPTH-entry FIFO that the decode stage drains. A branch/jump redirect flushes the queue and discards any in-flight response.

Parameters:
ADDR_WIDTH, 32, PC and instruction address width
INST_WIDTH, 32, instruction word width
DEPTH, 4, queue entries; power of 2, >= 2
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
inst_addr_o  out  ADDR_WIDTH  fetch address to inst_mem (= pc)
inst_ce_o  out  1  fetch request this cycle
inst_i  in  INST_WIDTH  inst_mem data; valid the cycle after a request
redirect_i  in  1  flush and restart fetch (branch taken / jump)
redirect_addr_i  in  ADDR_WIDTH  new fetch address; bits [1:0] ignored (forced 0)
deq_i  in  1  decode consumes head entry this cycle
valid_o  out  1  head entry valid
inst_o  out  INST_WIDTH  head instruction
inst_addr_out_o  out  ADDR_WIDTH  head instruction address
count_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, any time, including mid-operation): pc=RESET_PC, pending=0, wr_ptr=rd_ptr=0, count=0. Outputs: valid_o=0, inst_ce_o=0, count_o=0, inst_o=0, inst_addr_out_o=0, inst_addr_o=RESET_PC.
- Issue: issue = ~rst & ~redirect_i & (count + pending < DEPTH). inst_ce_o = issue; inst_addr_o = pc (combinational from register).
- On issue: pc <= pc + 4 (modulo 2^ADDR_WIDTH wrap); pending <= 1; pend_addr <= pc. Without issue: pending <= 0.
- Response: when pending=1 and no redirect, write {inst_i, pend_addr} at wr_ptr, and wr_ptr++.
- Pop: when deq_i & valid_o, rd_ptr++. deq_i while empty is ignored. Pointers wrap at DEPTH.
- count: push-only +1, pop-only -1, push and pop together leaves it unchanged. The issue rule guarantees count never exceeds DEPTH, so a push is never dropped.
- valid_o = (count != 0); inst_o/inst_addr_out_o = entry[rd_ptr], registered storage with no combinational path from inst_i (bypass disabled).
- Redirect has priority over everything else in its cycle:
  - count <= 0, pointers <= 0, pending <= 0; the in-flight inst_i is discarded.
  - pc <= {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00}; no issue that cycle.
  - A simultaneous deq_i is still consumed by decode, but the queue is flushed regardless.
- Latency, reset release/redirect at cycle N: issue at N+1 (or N+0 after reset, since pc already equals RESET_PC), inst_i at issue+1, valid_o at issue+2.
- Steady-state throughput: 1 instr/cycle while deq_i is held high.

Optional Feature:
FETCH_BYPASS_EN:
- Defined: when the queue is empty and a response arrives (pending & ~redirect_i), valid_o=1 and inst_o/inst_addr_out_o come from inst_i/pend_addr in the same cycle. If deq_i is also high, the entry is not written (count stays 0); otherwise it is written normally. Load-to-use latency is 1 cycle shorter.
- Undefined: all outputs come from queue storage only, per Behaviour.

Test Plan:
- Reset release, RESET_PC=0, memory returns addr|0xA000, deq_i=1 continuously -> inst_ce_o high every cycle with addresses 0,4,8,...; valid_o first high 2 cycles after the first issue; inst_o=0xA000, 0xA004, ... in order with no gaps.
- DEPTH=4, deq_i=0 -> exactly 4 requests (0,4,8,C), then inst_ce_o=0 and count_o=4. Pulse deq_i for 1 cycle -> inst_o=0xA000 popped, one request to 0x10, count_o returns to 4.
- Redirect to 0x103 while a request is in flight and count=2 -> next cycle count_o=0 and valid_o=0; the in-flight instruction never appears; next request address 0x100; first valid_o shows inst_addr_out_o=0x100.
- redirect_i and deq_i in the same cycle with count=3 -> count_o=0, no issue that cycle, next fetch at the redirect target.
- Async rst asserted mid-stream (count=3, pending=1) -> outputs at reset values immediately without waiting for a clock edge; after release, fetch restarts at RESET_PC.
- FETCH_BYPASS_EN defined, empty queue, deq_i=1 -> valid_o and inst_o=0xA000 in the same cycle inst_i arrives; count_o stays 0.
